// File: rtl/video_types.sv
// Shared video-subsystem types: OAM DMA state encoding and default register map.
package video_types;

    localparam logic [15:0] OAM_BASE_DEF = 16'hFE00;
    localparam int          DMA_LEN_DEF  = 160;
    localparam logic [15:0] REG_ADDR_DEF = 16'hFF46;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {src_hi,xx} into OAM, two cycles per byte.
// Define OAM_DMA_READBACK_EN to make the source register readable at REG_ADDR.
module oam_dma
    import video_types::*;
#(
    parameter logic [15:0] OAM_BASE    = OAM_BASE_DEF,
    parameter int          DMA_LEN     = DMA_LEN_DEF,
    parameter logic [15:0] REG_ADDR    = REG_ADDR_DEF,
    parameter int          START_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cfg_addr,
    input  logic        cfg_we,
    input  logic        cfg_re,
    input  logic [7:0]  cfg_wdata,
    output logic [7:0]  cfg_rdata,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_rdata,
    output logic        oam_we,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [7:0] LAST_DLY = (START_DELAY > 0) ? 8'(START_DELAY - 1) : 8'd0;

    dma_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] dly_q, dly_d;
    logic [7:0] byte_q, byte_d;
    logic       have_byte_q, have_byte_d;
    logic       done_q, done_d;

    logic       trigger;
    logic [7:0] eff_hi;

    assign trigger = cfg_we && (cfg_addr == REG_ADDR);
    // Echo RAM E000-FDFF mirrors C000-DDFF.
    assign eff_hi  = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
    assign done    = done_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        src_hi_d    = src_hi_q;
        dly_d       = dly_q;
        byte_d      = byte_q;
        have_byte_d = have_byte_q;
        done_d      = 1'b0;
        bus_req     = 1'b0;
        busy        = 1'b0;
        src_rd      = 1'b0;
        src_addr    = 16'h0000;
        oam_we      = 1'b0;
        oam_addr    = 16'h0000;
        oam_wdata   = 8'h00;

        case (state_q)
            ST_DELAY: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (dly_q == LAST_DLY) begin
                    state_d = ST_READ;
                end else begin
                    dly_d = dly_q + 8'd1;
                end
            end
            ST_READ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus_gnt) begin
                    src_rd      = 1'b1;
                    src_addr    = {eff_hi, idx_q};
                    have_byte_d = 1'b0;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                // Source data is only valid on the first WRITE cycle; hold it across a stall.
                if (!have_byte_q) begin
                    byte_d      = src_rdata;
                    have_byte_d = 1'b1;
                end
                if (bus_gnt) begin
                    oam_we    = 1'b1;
                    oam_addr  = OAM_BASE + {8'h00, idx_q};
                    oam_wdata = have_byte_q ? byte_q : src_rdata;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 8'd0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_READ;
                    end
                end
            end
            default: ;
        endcase

        // A new trigger always wins, including over the final write's done pulse.
        if (trigger) begin
            src_hi_d    = cfg_wdata;
            idx_d       = 8'd0;
            dly_d       = 8'd0;
            have_byte_d = 1'b0;
            done_d      = 1'b0;
            state_d     = (START_DELAY == 0) ? ST_READ : ST_DELAY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 8'd0;
            src_hi_q    <= 8'hFF;
            dly_q       <= 8'd0;
            byte_q      <= 8'h00;
            have_byte_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            src_hi_q    <= src_hi_d;
            dly_q       <= dly_d;
            byte_q      <= byte_d;
            have_byte_q <= have_byte_d;
            done_q      <= done_d;
        end
    end

`ifdef OAM_DMA_READBACK_EN
    logic [7:0] rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 8'hFF;
        end else begin
            rdata_q <= (cfg_re && (cfg_addr == REG_ADDR)) ? src_hi_q : 8'hFF;
        end
    end

    assign cfg_rdata = rdata_q;
`else
    logic unused_cfg_re;

    assign unused_cfg_re = cfg_re;
    assign cfg_rdata     = 8'hFF;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: scoreboarded source reads and OAM writes plus timing checks.
module tb_oam_dma;

    logic        clk;
    logic        reset_n;
    logic [15:0] cfg_addr;
    logic        cfg_we;
    logic        cfg_re;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;
    logic        bus_req;
    logic        bus_gnt;
    logic        src_rd;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;
    logic        oam_we;
    logic [15:0] oam_addr;
    logic [7:0]  oam_wdata;
    logic        busy;
    logic        done;

    oam_dma dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_addr  (cfg_addr),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .src_rd    (src_rd),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .oam_we    (oam_we),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .busy      (busy),
        .done      (done)
    );

    logic [23:0] exp_q[$];
    logic [15:0] exp_src_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int trig_cyc = 0;
    int done_cyc = 0;
    int wr_cnt, rd_cnt, done_cnt, busy_cnt, req_cnt, gap_strobes;
    bit rand_gnt = 1'b0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Source memory: data valid the cycle after src_rd, garbage otherwise.
    initial begin
        logic        r;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            r = src_rd;
            a = src_addr;
            @(posedge clk);
            #1;
            src_rdata = r ? mem(a) : 8'($urandom_range(0, 255));
        end
    end

    // Monitor / scoreboard consumer.
    initial forever begin
        @(negedge clk);
        if (busy)    busy_cnt++;
        if (bus_req) req_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!bus_gnt && (src_rd || oam_we)) gap_strobes++;
        if (src_rd || oam_we) check("strobe_overlap", 32'(src_rd && oam_we), 32'd0);
        if (src_rd) begin
            rd_cnt++;
            if (exp_src_q.size() == 0) check("src_extra", 32'(src_addr), 32'hFFFF_FFFF);
            else                       check("src_addr", 32'(src_addr), 32'(exp_src_q.pop_front()));
        end
        if (oam_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("oam_extra", 32'({oam_addr, oam_wdata}), 32'hFFFF_FFFF);
            else                   check("oam_write", 32'({oam_addr, oam_wdata}), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0; req_cnt = 0; gap_strobes = 0;
    endtask

    task automatic push_xfer(input logic [7:0] hi);
        logic [7:0] eff;
        eff = (hi >= 8'hE0) ? hi - 8'h20 : hi;
        for (int i = 0; i < 160; i++) begin
            exp_src_q.push_back({eff, 8'(i)});
            exp_q.push_back({16'hFE00 + 16'(i), mem({eff, 8'(i)})});
        end
    endtask

    task automatic do_trigger(input logic [7:0] hi);
        @(posedge clk);
        #1;
        cfg_addr  = 16'hFF46;
        cfg_wdata = hi;
        cfg_we    = 1'b1;
        trig_cyc  = cyc;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        exp_q.delete();
        exp_src_q.delete();
        push_xfer(hi);
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (wr_cnt < n && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (wr_cnt < n) check("write_timeout", 32'(wr_cnt), 32'(n));
    endtask

    task automatic wait_done();
        int k = 0;
        int start = done_cnt;
        while (done_cnt == start && k < 2000) begin
            @(posedge clk);
            #1;
            if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
            k++;
        end
        bus_gnt = 1'b1;
        if (done_cnt == start) check("done_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic restart_at(input int nbytes, input logic [7:0] hi1, input logic [7:0] hi2);
        clear_stats();
        do_trigger(hi1);
        wait_writes(nbytes);
        do_trigger(hi2);
        wait_done();
        check("restart_done_cnt", 32'(done_cnt), 32'd1);
        check("restart_duration", 32'(done_cyc - trig_cyc), 32'd322);
        check("restart_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n   = 1'b0;
        cfg_addr  = 16'h0000;
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        cfg_wdata = 8'h00;
        bus_gnt   = 1'b1;
        src_rdata = 8'h00;
        clear_stats();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_src_rd", 32'(src_rd), 32'd0);
        check("rst_oam_we", 32'(oam_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_rdata", 32'(cfg_rdata), 32'hFF);
        check("rst_oam_addr", 32'(oam_addr), 32'd0);
        check("rst_src_addr", 32'(src_addr), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic transfer with continuous grant.
        clear_stats();
        do_trigger(8'hC1);
        wait_done();
        check("a_duration", 32'(done_cyc - trig_cyc), 32'd322);
        check("a_busy_cycles", 32'(busy_cnt), 32'd321);
        check("a_req_cycles", 32'(req_cnt), 32'd321);
        check("a_writes", 32'(wr_cnt), 32'd160);
        check("a_reads", 32'(rd_cnt), 32'd160);
        check("a_done_cnt", 32'(done_cnt), 32'd1);
        check("a_q_empty", 32'(exp_q.size()), 32'd0);

        // Echo-folded source page.
        clear_stats();
        do_trigger(8'hE3);
        wait_done();
        check("b_done_cnt", 32'(done_cnt), 32'd1);
        check("b_src_q_empty", 32'(exp_src_q.size()), 32'd0);

        // Five-cycle grant gap in the WRITE of byte 40.
        clear_stats();
        do_trigger(8'h12);
        wait_writes(40);
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        wait_done();
        check("c_duration", 32'(done_cyc - trig_cyc), 32'd327);
        check("c_gap_strobes", 32'(gap_strobes), 32'd0);
        check("c_writes", 32'(wr_cnt), 32'd160);
        check("c_q_empty", 32'(exp_q.size()), 32'd0);

        // Restart mid-transfer, and restart on the final write.
        restart_at(100, 8'h33, 8'h80);
        restart_at(159, 8'h21, 8'hD7);

        // Random source page with random grant.
        clear_stats();
        rand_gnt = 1'b1;
        do_trigger(8'($urandom_range(0, 255)));
        wait_done();
        rand_gnt = 1'b0;
        check("r_gap_strobes", 32'(gap_strobes), 32'd0);
        check("r_done_cnt", 32'(done_cnt), 32'd1);
        check("r_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a transfer.
        clear_stats();
        do_trigger(8'h45);
        wait_writes(50);
        reset_n = 1'b0;
        @(negedge clk);
        check("e_busy", 32'(busy), 32'd0);
        check("e_strobes", 32'({src_rd, oam_we}), 32'd0);
        check("e_bus_req", 32'(bus_req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        exp_src_q.delete();
        clear_stats();
        repeat (20) @(posedge clk);
        #1;
        check("e_idle_strobes", 32'(wr_cnt + rd_cnt), 32'd0);
        check("e_idle_done", 32'(done_cnt), 32'd0);
        check("e_idle_busy", 32'(busy_cnt), 32'd0);

        // Register readback.
        clear_stats();
        do_trigger(8'h42);
        cfg_addr = 16'hFF46;
        cfg_re   = 1'b1;
        @(posedge clk);
        #1;
        cfg_re = 1'b0;
        @(negedge clk);
`ifdef OAM_DMA_READBACK_EN
        check("readback", 32'(cfg_rdata), 32'h42);
`else
        check("readback", 32'(cfg_rdata), 32'hFF);
`endif
        wait_done();
        check("f_done_cnt", 32'(done_cnt), 32'd1);
        check("f_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
